// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants, the per-stage header struct and the
// saturating helpers used by the pipeline register chain.
package pipe_pkg;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_PC   = 32'h0000_4180;
    localparam logic [4:0]  INT_CODE = 5'd0;

    // Fixed-width fields of one stage. Tnew and the payload have
    // per-instance widths, so they travel next to this struct as plain
    // vectors sized by the module parameters.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        bd;
        logic [4:0]  exc;
    } stage_hdr_t;

    // Tnew ageing: count down by one, never wrapping below zero.
    function automatic logic [31:0] satDec(input logic [31:0] value);
        return (value == 32'd0) ? 32'd0 : (value - 32'd1);
    endfunction

    // Performance counters stick at all-ones instead of wrapping.
    function automatic logic [31:0] satInc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : (value + 32'd1);
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// pipe_stage: one inter-stage register of the chain. It applies the
// priority reset > flush > hold > bubble > advance to a single stage.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int TNEW_W = 8,
    parameter int DATA_W = 96
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_flush,
    input  logic              i_hold,
    input  logic              i_bubble,
    input  stage_hdr_t        i_src_hdr,
    input  logic [TNEW_W-1:0] i_src_tnew,
    input  logic [DATA_W-1:0] i_src_data,
    output stage_hdr_t        o_hdr,
    output logic [TNEW_W-1:0] o_tnew,
    output logic [DATA_W-1:0] o_data
);

    stage_hdr_t        r_hdr;
    logic [TNEW_W-1:0] r_tnew;
    logic [DATA_W-1:0] r_data;
    logic [TNEW_W-1:0] w_tnewAged;

    assign w_tnewAged = TNEW_W'(satDec(32'(i_src_tnew)));

    // Stage register; a bubble keeps pc/bd so EPC and BD stay right for an empty slot.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hdr  <= '{valid: 1'b0, pc: RESET_PC, bd: 1'b0, exc: INT_CODE};
            r_tnew <= '0;
            r_data <= '0;
        end else if (i_flush) begin
            r_hdr  <= '{valid: 1'b0, pc: EXC_PC, bd: 1'b0, exc: INT_CODE};
            r_tnew <= '0;
            r_data <= '0;
        end else if (!i_hold) begin
            if (i_bubble) begin
                r_hdr  <= '{valid: 1'b0, pc: i_src_hdr.pc, bd: i_src_hdr.bd, exc: INT_CODE};
                r_tnew <= '0;
                r_data <= '0;
            end else begin
                r_hdr  <= i_src_hdr;
                r_tnew <= w_tnewAged;
                r_data <= i_src_data;
            end
        end
    end

    assign o_hdr  = r_hdr;
    assign o_tnew = r_tnew;
    assign o_data = r_data;

endmodule

// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: DEPTH back-to-back pipeline registers with uniform
// stall, bubble, flush and Tnew ageing. Optional performance counters are
// built only when the macro PIPE_PERF_EN is defined.
module pipe_reg_chain
    import pipe_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 96,
    parameter int TNEW_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req,
    input  logic [DEPTH-1:0]         stall,
    input  logic [DEPTH-1:0]         clr,
    input  logic                     in_valid,
    input  logic [31:0]              in_pc,
    input  logic                     in_bd,
    input  logic [4:0]               in_exc,
    input  logic [TNEW_W-1:0]        in_tnew,
    input  logic [DATA_W-1:0]        in_data,
    output logic [DEPTH-1:0]         out_valid,
    output logic [32*DEPTH-1:0]      out_pc,
    output logic [DEPTH-1:0]         out_bd,
    output logic [5*DEPTH-1:0]       out_exc,
    output logic [TNEW_W*DEPTH-1:0]  out_tnew,
    output logic [DATA_W*DEPTH-1:0]  out_data,
    output logic [31:0]              stall_cnt,
    output logic [31:0]              bubble_cnt
);

    logic [DEPTH-1:0]  w_hold;
    logic [DEPTH-1:0]  w_bubble;
    stage_hdr_t        w_srcHdr   [DEPTH];
    logic [TNEW_W-1:0] w_srcTnew  [DEPTH];
    logic [DATA_W-1:0] w_srcData  [DEPTH];
    stage_hdr_t        w_stageHdr [DEPTH];
    logic [TNEW_W-1:0] w_stageTnew[DEPTH];
    logic [DATA_W-1:0] w_stageData[DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        // A held stage forces every stage upstream of it to hold as well.
        assign w_hold[k] = |(stall >> k);

        if (k == 0) begin : g_head
            assign w_srcHdr[k]  = '{valid: in_valid, pc: in_pc, bd: in_bd, exc: in_exc};
            assign w_srcTnew[k] = in_tnew;
            assign w_srcData[k] = in_data;
            assign w_bubble[k]  = clr[k] | ~in_valid;
        end else begin : g_body
            assign w_srcHdr[k]  = w_stageHdr[k-1];
            assign w_srcTnew[k] = w_stageTnew[k-1];
            assign w_srcData[k] = w_stageData[k-1];
            assign w_bubble[k]  = clr[k] | (w_hold[k-1] & ~w_hold[k]);
        end

        pipe_stage #(
            .TNEW_W (TNEW_W),
            .DATA_W (DATA_W)
        ) u_stage (
            .clk        (clk),
            .reset      (reset),
            .i_flush    (req),
            .i_hold     (w_hold[k]),
            .i_bubble   (w_bubble[k]),
            .i_src_hdr  (w_srcHdr[k]),
            .i_src_tnew (w_srcTnew[k]),
            .i_src_data (w_srcData[k]),
            .o_hdr      (w_stageHdr[k]),
            .o_tnew     (w_stageTnew[k]),
            .o_data     (w_stageData[k])
        );

        assign out_valid[k]                 = w_stageHdr[k].valid;
        assign out_pc[32*k +: 32]           = w_stageHdr[k].pc;
        assign out_bd[k]                    = w_stageHdr[k].bd;
        assign out_exc[5*k +: 5]            = w_stageHdr[k].exc;
        assign out_tnew[TNEW_W*k +: TNEW_W] = w_stageTnew[k];
        assign out_data[DATA_W*k +: DATA_W] = w_stageData[k];
    end

`ifdef PIPE_PERF_EN
    logic [31:0]      r_stallCnt;
    logic [31:0]      r_bubbleCnt;
    logic [DEPTH-1:0] w_loadsBubble;

    assign w_loadsBubble = w_bubble & ~w_hold;

    // Saturating counts of held head cycles and of cycles in which any stage takes a bubble.
    always_ff @(posedge clk) begin
        if (!reset || req) begin
            r_stallCnt  <= '0;
            r_bubbleCnt <= '0;
        end else begin
            if (w_hold[0]) begin
                r_stallCnt <= satInc(r_stallCnt);
            end
            if (|w_loadsBubble) begin
                r_bubbleCnt <= satInc(r_bubbleCnt);
            end
        end
    end

    assign stall_cnt  = r_stallCnt;
    assign bubble_cnt = r_bubbleCnt;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb_pipe_reg_chain: directed walk through the pipeline behaviours followed
// by a randomized phase, all compared against a behavioural model.
module tb_pipe_reg_chain;

    localparam int D  = 2;
    localparam int DW = 96;
    localparam int TW = 8;

    logic             clk = 1'b0;
    logic             reset, req, in_valid, in_bd;
    logic [D-1:0]     stall, clr;
    logic [31:0]      in_pc;
    logic [4:0]       in_exc;
    logic [TW-1:0]    in_tnew;
    logic [DW-1:0]    in_data;
    logic [D-1:0]     out_valid, out_bd;
    logic [32*D-1:0]  out_pc;
    logic [5*D-1:0]   out_exc;
    logic [TW*D-1:0]  out_tnew;
    logic [DW*D-1:0]  out_data;
    logic [31:0]      stall_cnt, bubble_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          valid;
        logic [31:0]   pc;
        logic          bd;
        logic [4:0]    exc;
        logic [TW-1:0] tnew;
        logic [DW-1:0] data;
    } slot_t;

    slot_t       model[D];
    logic [31:0] mStallCnt;
    logic [31:0] mBubbleCnt;

    pipe_reg_chain #(.DEPTH(D), .DATA_W(DW), .TNEW_W(TW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .stall      (stall),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_pc      (in_pc),
        .in_bd      (in_bd),
        .in_exc     (in_exc),
        .in_tnew    (in_tnew),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_pc     (out_pc),
        .out_bd     (out_bd),
        .out_exc    (out_exc),
        .out_tnew   (out_tnew),
        .out_data   (out_data),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One clock edge of the reference: each stage is evaluated from the rules
    // using the contents the chain held before the edge.
    task automatic modelStep();
        slot_t old[D];
        slot_t src;
        logic  anyBubble;
        logic  held, upHeld;
        old = model;
        anyBubble = 1'b0;
        if (!reset || req) begin
            for (int k = 0; k < D; k++)
                model[k] = '{1'b0, (!reset ? 32'h0000_3000 : 32'h0000_4180), 1'b0, 5'd0, '0, '0};
            mStallCnt  = 0;
            mBubbleCnt = 0;
        end else begin
            for (int k = 0; k < D; k++) begin
                held = 1'b0;
                for (int j = k; j < D; j++) held = held | stall[j];
                upHeld = 1'b0;
                if (k > 0) for (int j = k - 1; j < D; j++) upHeld = upHeld | stall[j];
                if (k == 0) src = '{in_valid, in_pc, in_bd, in_exc, in_tnew, in_data};
                else        src = old[k-1];
                if (held) begin
                    model[k] = old[k];
                end else if (clr[k] || (k > 0 && upHeld) || (k == 0 && !in_valid)) begin
                    model[k] = '{1'b0, src.pc, src.bd, 5'd0, '0, '0};
                    anyBubble = 1'b1;
                end else begin
                    model[k] = src;
                    model[k].tnew = (src.tnew == 0) ? '0 : src.tnew - 1;
                end
            end
            if (stall != 0 && mStallCnt != 32'hFFFF_FFFF) mStallCnt++;
            if (anyBubble && mBubbleCnt != 32'hFFFF_FFFF) mBubbleCnt++;
        end
    endtask

    task automatic checkModel();
        for (int k = 0; k < D; k++) begin
            checkOutput($sformatf("s%0d.valid", k), 128'(out_valid[k]), 128'(model[k].valid));
            checkOutput($sformatf("s%0d.pc", k), 128'(out_pc[32*k +: 32]), 128'(model[k].pc));
            checkOutput($sformatf("s%0d.bd", k), 128'(out_bd[k]), 128'(model[k].bd));
            checkOutput($sformatf("s%0d.exc", k), 128'(out_exc[5*k +: 5]), 128'(model[k].exc));
            checkOutput($sformatf("s%0d.tnew", k), 128'(out_tnew[TW*k +: TW]), 128'(model[k].tnew));
            checkOutput($sformatf("s%0d.data", k), 128'(out_data[DW*k +: DW]), 128'(model[k].data));
        end
`ifdef PIPE_PERF_EN
        checkOutput("stall_cnt", 128'(stall_cnt), 128'(mStallCnt));
        checkOutput("bubble_cnt", 128'(bubble_cnt), 128'(mBubbleCnt));
`else
        checkOutput("stall_cnt", 128'(stall_cnt), 128'(0));
        checkOutput("bubble_cnt", 128'(bubble_cnt), 128'(0));
`endif
    endtask

    // Advance one edge with the currently driven inputs and compare afterwards.
    task automatic applyStimulus();
        @(posedge clk);
        modelStep();
        #1;
        checkModel();
    endtask

    initial begin
        for (int k = 0; k < D; k++) model[k] = '{1'b0, 32'd0, 1'b0, 5'd0, '0, '0};
        mStallCnt = 0;
        mBubbleCnt = 0;
        reset = 1'b0; req = 1'b0; stall = '0; clr = '0;
        in_valid = 1'b1; in_pc = 32'h0000_3000; in_bd = 1'b0; in_exc = 5'd0;
        in_tnew = 8'd2; in_data = 96'h1111;

        // Reset held low for two edges.
        applyStimulus();
        applyStimulus();
        checkOutput("rst.pc0", 128'(out_pc[31:0]), 128'(32'h0000_3000));
        checkOutput("rst.pc1", 128'(out_pc[63:32]), 128'(32'h0000_3000));
        checkOutput("rst.valid", 128'(out_valid), 128'(0));
        checkOutput("rst.tnew", 128'(out_tnew), 128'(0));

        // Flow with no holds.
        reset = 1'b1;
        applyStimulus();
        checkOutput("flow.s0pc", 128'(out_pc[31:0]), 128'(32'h0000_3000));
        checkOutput("flow.s0tnew", 128'(out_tnew[7:0]), 128'(1));
        in_pc = 32'h0000_3004;
        applyStimulus();
        checkOutput("flow.s1pc", 128'(out_pc[63:32]), 128'(32'h0000_3000));
        checkOutput("flow.s1tnew", 128'(out_tnew[15:8]), 128'(0));
        checkOutput("flow.s0pc2", 128'(out_pc[31:0]), 128'(32'h0000_3004));

        // stall[0] for three edges while stage 0 holds 0x3004.
        in_pc = 32'h0000_3008;
        stall = 2'b01;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("stall.s0pc", 128'(out_pc[31:0]), 128'(32'h0000_3004));
            checkOutput("stall.s1valid", 128'(out_valid[1]), 128'(0));
            checkOutput("stall.s1pc", 128'(out_pc[63:32]), 128'(32'h0000_3004));
            checkOutput("stall.s1exc", 128'(out_exc[9:5]), 128'(0));
        end
        stall = 2'b00;
        applyStimulus();
        checkOutput("resume.s1pc", 128'(out_pc[63:32]), 128'(32'h0000_3004));
        checkOutput("resume.s1valid", 128'(out_valid[1]), 128'(1));
        checkOutput("resume.s0pc", 128'(out_pc[31:0]), 128'(32'h0000_3008));

        // Clear of stage 1 while stage 0 holds pc 0x3010, bd 1, data 0xAB.
        in_pc = 32'h0000_3010; in_bd = 1'b1; in_data = 96'hAB;
        applyStimulus();
        clr = 2'b10;
        applyStimulus();
        checkOutput("clr.s1pc", 128'(out_pc[63:32]), 128'(32'h0000_3010));
        checkOutput("clr.s1bd", 128'(out_bd[1]), 128'(1));
        checkOutput("clr.s1data", 128'(out_data[191:96]), 128'(0));
        checkOutput("clr.s1valid", 128'(out_valid[1]), 128'(0));
        clr = 2'b00; in_bd = 1'b0;

        // Flush with both stages stalled.
        req = 1'b1; stall = 2'b11;
        applyStimulus();
        checkOutput("flush.pc0", 128'(out_pc[31:0]), 128'(32'h0000_4180));
        checkOutput("flush.pc1", 128'(out_pc[63:32]), 128'(32'h0000_4180));
        checkOutput("flush.bd", 128'(out_bd), 128'(0));
        checkOutput("flush.valid", 128'(out_valid), 128'(0));
        req = 1'b0;

        // Five held head cycles then a flush clears the counters.
        stall = 2'b01; in_pc = 32'h0000_3020;
        for (int i = 0; i < 5; i++) applyStimulus();
`ifdef PIPE_PERF_EN
        checkOutput("perf.stall5", 128'(stall_cnt), 128'(5));
        checkOutput("perf.bubble5", 128'(bubble_cnt), 128'(5));
`endif
        stall = 2'b00; req = 1'b1;
        applyStimulus();
        checkOutput("perf.stallClr", 128'(stall_cnt), 128'(0));
        checkOutput("perf.bubbleClr", 128'(bubble_cnt), 128'(0));
        req = 1'b0;

        // Last-stage stall freezes the chain with no bubble inside.
        stall = 2'b10; clr = 2'b11;
        applyStimulus();
        checkOutput("freeze.s0pc", 128'(out_pc[31:0]), 128'(32'h0000_4180));
        checkOutput("freeze.s1pc", 128'(out_pc[63:32]), 128'(32'h0000_4180));
        stall = 2'b00; clr = 2'b00;

        // Randomized phase.
        for (int i = 0; i < 400; i++) begin
            reset    = ($urandom_range(0, 63) != 0);
            req      = ($urandom_range(0, 31) == 0);
            stall    = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
            clr      = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
            in_valid = ($urandom_range(0, 3) != 0);
            in_pc    = $urandom & 32'hFFFF_FFFC;
            in_bd    = 1'($urandom_range(0, 1));
            in_exc   = 5'($urandom_range(0, 31));
            in_tnew  = 8'($urandom_range(0, 3));
            in_data  = {$urandom, $urandom, $urandom};
            applyStimulus();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
